// File: rtl/rca_lsq_arbiter_pkg.sv
// rtl/rca_lsq_arbiter_pkg.sv - shared configuration and types for the LSQ arbiter
package rca_config;
  localparam int XLEN              = 32;
  localparam int LSQ_ARB_PORTS     = 4;
  localparam int LSQ_ARB_MAX_LOADS = 4;
endpackage

package rca_types;
  import rca_config::*;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [2:0]      fn3;
    logic            load;
    logic            store;
  } lsq_req_t;

  typedef logic [$clog2(LSQ_ARB_PORTS)-1:0] ou_port_id_t;
endpackage

// File: rtl/rca_lsq_tag_fifo.sv
// rtl/rca_lsq_tag_fifo.sv - in-order FIFO of issuing port ids for outstanding loads
module rca_lsq_tag_fifo
  import rca_types::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  ou_port_id_t push_id,
  input  logic        pop,
  output ou_port_id_t head,
  output logic        full,
  output logic        empty,
  output logic [CW-1:0] count
);

  ou_port_id_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

  // Pointers rely on DEPTH being a power of two to wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rca_lsq_arbiter.sv
// rtl/rca_lsq_arbiter.sv - round-robin sharing of the RCA LSQ port among OUs
module rca_lsq_arbiter
  import rca_config::*;
  import rca_types::*;
#(
  parameter int NUM_PORTS = LSQ_ARB_PORTS,
  parameter int MAX_LOADS = LSQ_ARB_MAX_LOADS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0][XLEN-1:0] ou_addr,
  input  logic [NUM_PORTS-1:0][XLEN-1:0] ou_data,
  input  logic [NUM_PORTS-1:0][2:0]      ou_fn3,
  input  logic [NUM_PORTS-1:0]           ou_load,
  input  logic [NUM_PORTS-1:0]           ou_store,
  input  logic [NUM_PORTS-1:0]           ou_new_request,
  output logic [NUM_PORTS-1:0]           ou_lsq_full,
  output logic [XLEN-1:0]                ou_load_data,
  output logic [NUM_PORTS-1:0]           ou_load_complete,
  output logic [XLEN-1:0]                addr,
  output logic [XLEN-1:0]                data,
  output logic [2:0]                     fn3,
  output logic                           load,
  output logic                           store,
  output logic                           new_request,
  input  logic                           lsq_full,
  input  logic [XLEN-1:0]                load_data,
  input  logic                           load_complete,
  output logic                           err_spurious
);

  localparam int CW = $clog2(MAX_LOADS) + 1;

  lsq_req_t              stage;
  ou_port_id_t           rr_ptr, winner, tag_head;
  logic                  grant, stage_free, loads_ok, push, pop;
  logic                  tag_full, tag_empty;
  logic [CW-1:0]         load_cnt;
  logic [NUM_PORTS-1:0]  eligible;

  assign stage_free = !new_request || !lsq_full;
  assign loads_ok   = load_cnt < CW'(MAX_LOADS);
  assign eligible   = ou_new_request & (~ou_load | {NUM_PORTS{loads_ok}});

  // Scan from rr_ptr upward; reset also blocks grants so every port sees full.
  always_comb begin
    int idx;
    idx    = 0;
    grant  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_PORTS;
      if (!grant && eligible[idx]) begin
        grant  = 1'b1;
        winner = ou_port_id_t'(idx);
      end
    end
    grant = grant && stage_free && rst;
  end

  always_comb begin
    ou_lsq_full = '1;
    if (grant) ou_lsq_full[winner] = 1'b0;
  end

  assign push = grant && ou_load[winner];
  assign pop  = load_complete && !tag_empty;

  always_comb begin
    ou_load_complete = '0;
    if (pop) ou_load_complete[tag_head] = 1'b1;
  end

  assign ou_load_data = load_data;

  rca_lsq_tag_fifo #(.DEPTH(MAX_LOADS)) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .push_id (winner),
    .pop     (pop),
    .head    (tag_head),
    .full    (tag_full),
    .empty   (tag_empty),
    .count   (load_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage       <= '0;
      new_request <= 1'b0;
      rr_ptr      <= '0;
    end else if (grant) begin
      stage.addr  <= ou_addr[winner];
      stage.data  <= ou_data[winner];
      stage.fn3   <= ou_fn3[winner];
      stage.load  <= ou_load[winner];
      stage.store <= ou_store[winner];
      new_request <= 1'b1;
      rr_ptr      <= (winner == ou_port_id_t'(NUM_PORTS - 1)) ? '0 : winner + ou_port_id_t'(1);
    end else if (stage_free) begin
      new_request <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            err_spurious <= 1'b0;
    else if (load_complete && tag_empty) err_spurious <= 1'b1;
  end

  assign addr  = stage.addr;
  assign data  = stage.data;
  assign fn3   = stage.fn3;
  assign load  = stage.load;
  assign store = stage.store;

endmodule

// File: tb/tb_rca_lsq_arbiter.sv
// tb/tb_rca_lsq_arbiter.sv - directed self-checking bench for rca_lsq_arbiter
module tb_rca_lsq_arbiter;
  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0][31:0] ou_addr, ou_data;
  logic [N-1:0][2:0] ou_fn3;
  logic [N-1:0]      ou_load, ou_store, ou_new_request;
  logic [N-1:0]      ou_lsq_full, ou_load_complete;
  logic [31:0]       ou_load_data, addr, data, load_data;
  logic [2:0]        fn3;
  logic              load, store, new_request, lsq_full, load_complete, err_spurious;

  int errors = 0;
  int checks = 0;
  logic [3:0] ret_exp [4] = '{4'b1000, 4'b0010, 4'b1000, 4'b0000};

  always #5 clk = ~clk;

  rca_lsq_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .ou_addr          (ou_addr),
    .ou_data          (ou_data),
    .ou_fn3           (ou_fn3),
    .ou_load          (ou_load),
    .ou_store         (ou_store),
    .ou_new_request   (ou_new_request),
    .ou_lsq_full      (ou_lsq_full),
    .ou_load_data     (ou_load_data),
    .ou_load_complete (ou_load_complete),
    .addr             (addr),
    .data             (data),
    .fn3              (fn3),
    .load             (load),
    .store            (store),
    .new_request      (new_request),
    .lsq_full         (lsq_full),
    .load_data        (load_data),
    .load_complete    (load_complete),
    .err_spurious     (err_spurious)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] nfull(input int p);
    logic [3:0] m;
    m    = 4'hF;
    m[p] = 1'b0;
    return 32'(m);
  endfunction

  function automatic logic [31:0] oh(input int p);
    logic [3:0] m;
    m    = 4'h0;
    m[p] = 1'b1;
    return 32'(m);
  endfunction

  task automatic set_port(input int p, input logic req, input logic ld, input logic st,
                          input logic [31:0] a);
    ou_new_request[p] = req;
    ou_load[p]        = ld;
    ou_store[p]       = st;
    ou_addr[p]        = a;
    ou_data[p]        = a ^ 32'h5A5A0000;
    ou_fn3[p]         = 3'(p);
  endtask

  task automatic idle_all();
    for (int p = 0; p < N; p++) set_port(p, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    idle_all();
    lsq_full      = 1'b0;
    load_complete = 1'b0;
    load_data     = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", 32'(new_request), 32'h0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_ldst", 32'({load, store}), 32'h0);
    chk("rst_full", 32'(ou_lsq_full), 32'hF);
    chk("rst_lc", 32'(ou_load_complete), 32'h0);
    chk("rst_err", 32'(err_spurious), 32'h0);

    // Round-robin with every port requesting a store
    @(negedge clk);
    rst = 1'b1;
    for (int p = 0; p < N; p++) set_port(p, 1'b1, 1'b0, 1'b1, 32'h1000 + p * 16);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      #1 chk("rr_gnt", 32'(ou_lsq_full), nfull(k % 4));
      @(posedge clk); #1;
      chk("rr_req", 32'(new_request), 32'h1);
      chk("rr_addr", addr, 32'h1000 + (k % 4) * 16);
      chk("rr_data", data, (32'h1000 + (k % 4) * 16) ^ 32'h5A5A0000);
      chk("rr_fn3", 32'(fn3), 32'(k % 4));
    end
    @(negedge clk);
    idle_all();
    @(posedge clk); #1 chk("idle_req", 32'(new_request), 32'h0);

    // Stall hold
    @(negedge clk);
    set_port(2, 1'b1, 1'b0, 1'b1, 32'h100);
    #1 chk("st_gnt2", 32'(ou_lsq_full), nfull(2));
    @(negedge clk);
    set_port(2, 1'b0, 1'b0, 1'b0, 32'h0);
    set_port(1, 1'b1, 1'b0, 1'b1, 32'h200);
    lsq_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk("st_addr", addr, 32'h100);
      chk("st_req", 32'(new_request), 32'h1);
      chk("st_full", 32'(ou_lsq_full), 32'hF);
    end
    @(negedge clk);
    lsq_full = 1'b0;
    #1 chk("st_gnt1", 32'(ou_lsq_full), nfull(1));
    @(posedge clk); #1 chk("st_addr1", addr, 32'h200);
    @(negedge clk);
    idle_all();

    // Load routing: loads from 3, 1, 3 then four returns
    set_port(3, 1'b1, 1'b1, 1'b0, 32'h300);
    #1 chk("ld_gnt3", 32'(ou_lsq_full), nfull(3));
    @(posedge clk); #1 chk("ld_load", 32'({load, store}), 32'h2);
    @(negedge clk);
    set_port(3, 1'b0, 1'b0, 1'b0, 32'h0);
    set_port(1, 1'b1, 1'b1, 1'b0, 32'h310);
    #1 chk("ld_gnt1", 32'(ou_lsq_full), nfull(1));
    @(negedge clk);
    set_port(1, 1'b0, 1'b0, 1'b0, 32'h0);
    set_port(3, 1'b1, 1'b1, 1'b0, 32'h320);
    #1 chk("ld_gnt3b", 32'(ou_lsq_full), nfull(3));
    @(negedge clk);
    idle_all();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      load_complete = 1'b1;
      load_data     = 32'hA + k;
      #1;
      chk("ret_oh", 32'(ou_load_complete), 32'(ret_exp[k]));
      chk("ret_data", ou_load_data, 32'hA + k);
      chk("ret_err", 32'(err_spurious), 32'h0);
    end
    @(posedge clk); #1 chk("spur_err", 32'(err_spurious), 32'h1);
    @(negedge clk);
    load_complete = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rst2_err", 32'(err_spurious), 32'h0);

    // Tag-full masking: four loads from port 2
    set_port(2, 1'b1, 1'b1, 1'b0, 32'h400);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1 chk("tf_fill", 32'(ou_lsq_full), nfull(2));
    end
    @(negedge clk);
    set_port(2, 1'b0, 1'b0, 1'b0, 32'h0);
    set_port(0, 1'b1, 1'b1, 1'b0, 32'h500);
    set_port(1, 1'b1, 1'b0, 1'b1, 32'h600);
    #1 chk("tf_mask", 32'(ou_lsq_full), nfull(1));
    @(posedge clk); #1;
    chk("tf_store", 32'({load, store}), 32'h1);
    chk("tf_saddr", addr, 32'h600);
    @(negedge clk);
    set_port(1, 1'b0, 1'b0, 1'b0, 32'h0);
    load_complete = 1'b1;
    load_data     = 32'h55;
    #1;
    chk("tf_pop", 32'(ou_load_complete), oh(2));
    chk("tf_still", 32'(ou_lsq_full), 32'hF);
    @(negedge clk);
    load_complete = 1'b0;
    #1 chk("tf_unmask", 32'(ou_lsq_full), nfull(0));
    @(posedge clk); #1;
    chk("tf_load", 32'({load, store}), 32'h2);
    chk("tf_laddr", addr, 32'h500);
    @(negedge clk);
    idle_all();

    // Simultaneous push/pop at load_cnt==2 (FIFO holds 2,2,2,0)
    load_complete = 1'b1;
    #1 chk("pp_pop1", 32'(ou_load_complete), oh(2));
    @(negedge clk);
    #1 chk("pp_pop2", 32'(ou_load_complete), oh(2));
    @(negedge clk);
    set_port(3, 1'b1, 1'b1, 1'b0, 32'h700);
    #1;
    chk("pp_pop3", 32'(ou_load_complete), oh(2));
    chk("pp_gnt3", 32'(ou_lsq_full), nfull(3));
    @(negedge clk);
    idle_all();
    #1 chk("pp_ord0", 32'(ou_load_complete), oh(0));
    @(negedge clk);
    #1;
    chk("pp_ord3", 32'(ou_load_complete), oh(3));
    chk("pp_err0", 32'(err_spurious), 32'h0);
    @(negedge clk);
    #1 chk("pp_empty", 32'(ou_load_complete), 32'h0);
    @(posedge clk); #1 chk("pp_err1", 32'(err_spurious), 32'h1);
    @(negedge clk);
    load_complete = 1'b0;

    // Mid-operation reset with loads from 0, 1, 2 outstanding
    set_port(0, 1'b1, 1'b1, 1'b0, 32'h800);
    #1 chk("mr_gnt0", 32'(ou_lsq_full), nfull(0));
    @(negedge clk);
    set_port(0, 1'b0, 1'b0, 1'b0, 32'h0);
    set_port(1, 1'b1, 1'b1, 1'b0, 32'h810);
    @(negedge clk);
    set_port(1, 1'b0, 1'b0, 1'b0, 32'h0);
    set_port(2, 1'b1, 1'b1, 1'b0, 32'h820);
    @(posedge clk); #1 chk("mr_req", 32'({new_request, load}), 32'h3);
    @(negedge clk);
    for (int p = 0; p < N; p++) set_port(p, 1'b1, 1'b0, 1'b1, 32'h900 + p * 16);
    rst = 1'b0;
    #1;
    chk("mr_clr_req", 32'({new_request, load, store}), 32'h0);
    chk("mr_clr_addr", addr, 32'h0);
    chk("mr_clr_data", data, 32'h0);
    chk("mr_clr_fn3", 32'(fn3), 32'h0);
    chk("mr_clr_full", 32'(ou_lsq_full), 32'hF);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("mr_prio0", 32'(ou_lsq_full), nfull(0));
    @(posedge clk); #1 chk("mr_addr0", addr, 32'h900);
    @(negedge clk);
    idle_all();
    load_complete = 1'b1;
    #1;
    chk("mr_notag", 32'(ou_load_complete), 32'h0);
    chk("mr_err0", 32'(err_spurious), 32'h0);
    @(posedge clk); #1 chk("mr_err1", 32'(err_spurious), 32'h1);
    @(negedge clk);
    load_complete = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rca_lsq_arbiter.md
# rca_lsq_arbiter

Shares the single LSQ request/response port of the RCA among `NUM_PORTS` operational units (OUs). Each OU presents its standard LS interface (`addr`/`data`/`fn3`/`load`/`store`/`new_request`, `lsq_full`, `load_data`/`load_complete`).
- The arbiter grants requests round-robin and registers the winner into a one-entry output stage.
- It records the issuing port of every load in an in-order tag FIFO, and routes each `load_complete` back to that port.
- It sits between the OU array and the LSQ.

## Interface
Parameters:
- `NUM_PORTS`, 4: number of OU requesters; must be ≥2.
- `MAX_LOADS`, 4: maximum loads in flight, counted from grant to `load_complete`; must be a power of two.

Ports (`[N]` is indexed per port):
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous reset, active-low.
- `ou_addr[N]`, `ou_data[N]`  in  XLEN  per-port request address and store data.
- `ou_fn3[N]`  in  3  per-port access function code.
- `ou_load[N]`, `ou_store[N]`  in  1  per-port request type.
- `ou_new_request[N]`  in  1  per-port request valid; held until accepted.
- `ou_lsq_full[N]`  out  1  per-port back-pressure; low only in the cycle that port is granted.
- `ou_load_data`  out  XLEN  broadcast copy of `load_data`.
- `ou_load_complete[N]`  out  1  one-hot load return strobe.
- `addr`, `data`  out  XLEN  to the LSQ.
- `fn3`  out  3  to the LSQ.
- `load`, `store`, `new_request`  out  1  to the LSQ.
- `lsq_full`  in  1  LSQ back-pressure.
- `load_data`  in  XLEN  LSQ load result.
- `load_complete`  in  1  LSQ load return; returns are in issue order.
- `err_spurious`  out  1  sticky flag: `load_complete` arrived with no load outstanding.

## Operation
- **Acceptance rules:**
  - An OU request is accepted in the cycle `ou_new_request[i] && !ou_lsq_full[i]`.
  - An LSQ request is accepted in the cycle `new_request && !lsq_full`.
- **Output stage:**
  - Holds one registered request, valid = `new_request`.
  - `stage_free = !new_request || !lsq_full`.
- **Eligibility:** port i is eligible when `ou_new_request[i]` is set and either:
  - the request is not a load, or
  - `load_cnt < MAX_LOADS`, using the registered count with no same-cycle bypass.
- **Grant:**
  - Made only when `stage_free`.
  - Winner is the first eligible port scanning from `rr_ptr` upward, wrapping modulo `NUM_PORTS`.
  - On a grant: capture the winner's fields into the output stage, then set `rr_ptr <= winner+1` (mod N).
  - With no grant, `rr_ptr` holds.
  - If nothing is granted and the stage is free, `new_request <= 0`.
- **Tag push:** a granted load pushes its port index into the tag FIFO in the grant cycle, so the FIFO order equals LSQ issue order.
- **Load return:**
  - `load_complete` pops the FIFO head h and drives `ou_load_complete[h]=1` combinationally in the same cycle.
  - `ou_load_data` = `load_data`, always.
- **Count update:**
  - Push and pop in the same cycle: `load_cnt` unchanged.
  - Pointers wrap at `MAX_LOADS`.
- **Spurious return:** `load_complete` with `load_cnt==0` means no pop, all `ou_load_complete` stay 0, and `err_spurious` is set. It clears only on reset.
- **Stores:** push no tag and never receive a return.

## Timing
- **Reset (asynchronous, `rst` low):**
  - Registered outputs clear: `new_request`, `load`, `store`, `addr`, `data`, `fn3` all 0.
  - `rr_ptr=0`, FIFO empty, `load_cnt=0`, `err_spurious=0`.
  - Resulting combinational outputs: all `ou_lsq_full=1`, all `ou_load_complete=0`.
- **Mid-operation reset:** in-flight tags are discarded. The LSQ is reset with the array.
- **Latency:**
  - OU acceptance to `new_request` high: 1 cycle.
  - Back-to-back grants at 1 per cycle are possible while `lsq_full=0`.
- **Stall:** while `new_request && lsq_full`, the output stage fields are stable and every `ou_lsq_full=1`.
- **Full FIFO:** at `load_cnt==MAX_LOADS`, load requests are masked for grant but stores still grant. A pop in cycle t unmasks loads from cycle t+1.
- **Combinational paths:** `ou_lsq_full` depends on `lsq_full` and `ou_new_request`. `ou_load_complete` depends on `load_complete`.

## Structure
- Shared package `rca_config`: `LSQ_ARB_PORTS`, `LSQ_ARB_MAX_LOADS`.
- Shared package `rca_types`: `lsq_req_t {addr, data, fn3, load, store}` and `ou_port_id_t` (width `$clog2(NUM_PORTS)`).
- Sub-module `rca_lsq_tag_fifo`:
  - Depth `MAX_LOADS`, element `ou_port_id_t`.
  - Has push/pop/full/empty and a count of width `$clog2(MAX_LOADS)+1`.
  - Uses the same asynchronous active-low reset.

## Test plan
- **Round-robin fairness:** ports 0–3 all request continuously, `lsq_full=0`. Grants go 0,1,2,3,0; one `new_request` per cycle; first `new_request` one cycle after reset release.
- **Stall hold:** port 2 is granted with addr 0x100 and `lsq_full=1` for 3 cycles. `addr` stays 0x100 and every `ou_lsq_full=1` throughout. Port 1 is granted in the cycle `lsq_full` drops.
- **Load routing:** loads are issued from ports 3, 1, 3, then 4 `load_complete` pulses with data 0xA,0xB,0xC,0xD. `ou_load_complete` goes 3,1,3,… with matching `ou_load_data`. The 4th pulse sets `err_spurious`.
- **Tag-full masking:** with `MAX_LOADS=4`, 4 loads are outstanding; port 0 requests a load and port 1 a store. Port 1 is granted and port 0 waits. One `load_complete` lets port 0 be granted the next cycle.
- **Simultaneous push/pop:** a load grant coincides with `load_complete` at `load_cnt=2`. `load_cnt` stays 2 and FIFO order is preserved.
- **Mid-operation reset:** `rst` is pulled low with 3 loads outstanding and `new_request` high. Outputs clear immediately; after release, port 0 has first priority.
